// File: rtl/mem_stage.sv
// mem_stage -- memory-access pipeline stage.
//   Registers the EX->MEM bus, aligns and sign/zero-extends load data returned by
//   the data SRAM, and produces the MEM->WB bus plus the MEM->EX forwarding bus.
//   Non-load instructions pass through with no added latency. A load whose data
//   has not yet arrived raises stallreq_mem until data_sram_rvalid pulses.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   stall[5:0]          pipeline stall vector; [3] holds MEM input reg, [4] holds WB input reg
//   stallreq_mem        high while a load is waiting on read data
//   ex2mem_bus          {lsu_op[6:0], data_ram_sel[7:0], sel_load, rf_we, rf_waddr[4:0],
//                        ex_result[63:0], pc[63:0], inst[31:0]}
//   data_sram_rdata     64-bit read data, qualified by data_sram_rvalid (1-cycle pulse)
//   mem2wb_bus          {rf_we, rf_waddr[4:0], rf_wdata[63:0], pc[63:0], inst[31:0], misalign}
//   mem2ex_fwd          {rf_we, rf_waddr[4:0], rf_wdata[63:0]}
//
// Configuration:
//   MEM_MISALIGN_CHK_EN  when defined, misaligned lh/lhu/lw/lwu/ld set misalign and
//                        suppress the register write on both output buses.

module mem_stage #(
    parameter int EX2MEM_WD = 182,
    parameter int MEM2WB_WD = 167,
    parameter int MEM2EX_WD = 70
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           stall,
    output logic                 stallreq_mem,
    input  logic [EX2MEM_WD-1:0] ex2mem_bus,
    input  logic [63:0]          data_sram_rdata,
    input  logic                 data_sram_rvalid,
    output logic [MEM2WB_WD-1:0] mem2wb_bus,
    output logic [MEM2EX_WD-1:0] mem2ex_fwd
);

    // ------------------------------------------------------------------
    // Load FSM state encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no load outstanding (or load completing this cycle)
        S_WAIT = 2'd1,   // load issued, read data not yet returned
        S_HOLD = 2'd2    // read data captured, WB stalled; replay from buffer
    } state_t;

    // ------------------------------------------------------------------
    // Input pipeline register
    // ------------------------------------------------------------------
    logic [EX2MEM_WD-1:0] ex2mem_q;
    logic [EX2MEM_WD-1:0] ex2mem_d;

    // stall[3] without stall[4] means MEM is frozen but WB moves on, so a
    // bubble is inserted; with both set the instruction is simply held.
    always_comb begin
        ex2mem_d = ex2mem_q;
        if (!stall[3]) begin
            ex2mem_d = ex2mem_bus;
        end else if (!stall[4]) begin
            ex2mem_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex2mem_q <= '0;
        end else begin
            ex2mem_q <= ex2mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [6:0]  lsu_op;
    logic [7:0]  data_ram_sel;
    logic        sel_load;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] ex_result;
    logic [63:0] pc;
    logic [31:0] inst;

    assign {lsu_op, data_ram_sel, sel_load, rf_we, rf_waddr,
            ex_result, pc, inst} = ex2mem_q;

    // lsu_op is one-hot; any set bit marks a load.
    logic is_load;
    assign is_load = |lsu_op;

    // ------------------------------------------------------------------
    // Load FSM and read-data buffer
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [63:0] rbuf_q;

    // Read data that arrives while WB is stalled would be lost after its
    // one-cycle pulse, so it is captured and replayed from rbuf_q in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rbuf_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_load) begin
                        if (!data_sram_rvalid) begin
                            state_q <= S_WAIT;
                        end else if (stall[4]) begin
                            rbuf_q  <= data_sram_rdata;
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!is_load) begin
                        // Load flushed out by a bubble; nothing left to wait for.
                        state_q <= S_IDLE;
                    end else if (data_sram_rvalid) begin
                        if (stall[4]) begin
                            rbuf_q  <= data_sram_rdata;
                            state_q <= S_HOLD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall[4]) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stall must drop in the very cycle rvalid arrives so the pipeline can
    // advance with the combinationally-used data; hence not registered.
    assign stallreq_mem = is_load && !data_sram_rvalid && (state_q != S_HOLD);

    // Load data is usable this cycle if it is arriving now or already buffered.
    logic data_ok;
    assign data_ok = (state_q == S_HOLD) || data_sram_rvalid;

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    logic [63:0] load_raw;
    logic [63:0] load_shift;
    logic [63:0] load_ext;

    assign load_raw   = (state_q == S_HOLD) ? rbuf_q : data_sram_rdata;
    // Byte offset within the doubleword selects the starting byte lane.
    assign load_shift = load_raw >> {ex_result[2:0], 3'b000};

    always_comb begin
        load_ext = load_shift;
        unique case (lsu_op)
            7'b100_0000: load_ext = {{56{load_shift[7]}},  load_shift[7:0]};   // lb
            7'b010_0000: load_ext = {56'd0,                load_shift[7:0]};   // lbu
            7'b001_0000: load_ext = {{48{load_shift[15]}}, load_shift[15:0]};  // lh
            7'b000_1000: load_ext = {48'd0,                load_shift[15:0]};  // lhu
            7'b000_0100: load_ext = {{32{load_shift[31]}}, load_shift[31:0]};  // lw
            7'b000_0010: load_ext = {32'd0,                load_shift[31:0]};  // lwu
            default:     load_ext = load_shift;                                // ld / non-load
        endcase
    end

    logic [63:0] rf_wdata;
    assign rf_wdata = sel_load ? load_ext : ex_result;

    // ------------------------------------------------------------------
    // Misalignment detection (optional)
    // ------------------------------------------------------------------
    logic misalign;

`ifdef MEM_MISALIGN_CHK_EN
    always_comb begin
        misalign = 1'b0;
        if ((lsu_op[4] || lsu_op[3]) && ex_result[0]) begin
            misalign = 1'b1;
        end
        if ((lsu_op[2] || lsu_op[1]) && (ex_result[1:0] != 2'b00)) begin
            misalign = 1'b1;
        end
        if (lsu_op[0] && (ex_result[2:0] != 3'b000)) begin
            misalign = 1'b1;
        end
    end
`else
    // Misaligned loads simply return the shifted data and write normally.
    assign misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output buses
    // ------------------------------------------------------------------
    logic wb_we;
    logic fwd_we;

    assign wb_we  = rf_we && !misalign;
    // EX must not forward a load result that has not arrived yet.
    assign fwd_we = wb_we && (!is_load || data_ok);

    assign mem2wb_bus = {wb_we, rf_waddr, rf_wdata, pc, inst, misalign};
    assign mem2ex_fwd = {fwd_we, rf_waddr, rf_wdata};

    // Byte-lane selects and unrelated stall bits are not needed for loads.
    logic unused_sigs;
    assign unused_sigs = ^{data_ram_sel, stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic         stallreq_mem;
    logic [181:0] ex2mem_bus;
    logic [63:0]  data_sram_rdata;
    logic         data_sram_rvalid;
    logic [166:0] mem2wb_bus;
    logic [69:0]  mem2ex_fwd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .stallreq_mem     (stallreq_mem),
        .ex2mem_bus       (ex2mem_bus),
        .data_sram_rdata  (data_sram_rdata),
        .data_sram_rvalid (data_sram_rvalid),
        .mem2wb_bus       (mem2wb_bus),
        .mem2ex_fwd       (mem2ex_fwd)
    );

    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [63:0] wb_wdata;
    logic        wb_misalign;
    logic        fwd_we;
    logic [4:0]  fwd_waddr;
    logic [63:0] fwd_wdata;

    assign wb_we       = mem2wb_bus[166];
    assign wb_waddr    = mem2wb_bus[165:161];
    assign wb_wdata    = mem2wb_bus[160:97];
    assign wb_misalign = mem2wb_bus[0];
    assign fwd_we      = mem2ex_fwd[69];
    assign fwd_waddr   = mem2ex_fwd[68:64];
    assign fwd_wdata   = mem2ex_fwd[63:0];

    localparam logic [63:0] ST_IDLE = 64'd0;
    localparam logic [63:0] ST_WAIT = 64'd1;
    localparam logic [63:0] ST_HOLD = 64'd2;

    localparam logic [6:0] OP_LB  = 7'b100_0000;
    localparam logic [6:0] OP_LBU = 7'b010_0000;
    localparam logic [6:0] OP_LH  = 7'b001_0000;
    localparam logic [6:0] OP_LHU = 7'b000_1000;
    localparam logic [6:0] OP_LW  = 7'b000_0100;
    localparam logic [6:0] OP_LWU = 7'b000_0010;
    localparam logic [6:0] OP_LD  = 7'b000_0001;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [181:0] mk(input logic [6:0] op, input logic sl, input logic we,
                                        input logic [4:0] wa, input logic [63:0] res);
        return {op, 8'hFF, sl, we, wa, res, 64'h0000_0000_0000_1000, 32'h0000_0013};
    endfunction

    // Present one instruction to the MEM input register; it is in MEM on return.
    task automatic issue(input logic [181:0] b);
        ex2mem_bus = b;
        @(posedge clk);
        #1;
        ex2mem_bus = '0;
    endtask

    function automatic logic [63:0] cur_state();
        return 64'(dut.state_q);
    endfunction

    // Load whose data returns in the same cycle, WB not stalled.
    task automatic run_load(input string tag, input logic [6:0] op, input logic [63:0] addr,
                            input logic [63:0] rd, input logic [63:0] exp);
        issue(mk(op, 1'b1, 1'b1, 5'd10, addr));
        data_sram_rdata  = rd;
        data_sram_rvalid = 1'b1;
        @(negedge clk);
        chk({tag, "_wdata"}, wb_wdata, exp);
        chk({tag, "_fwd_wdata"}, fwd_wdata, exp);
        chk({tag, "_stallreq"}, 64'(stallreq_mem), 64'd0);
        chk({tag, "_fwd_we"}, 64'(fwd_we), 64'd1);
        @(posedge clk);
        #1;
        data_sram_rvalid = 1'b0;
        chk({tag, "_state_after"}, cur_state(), ST_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stall_cnt;
        int fwd_low_cnt;

        rst              = 1'b1;
        stall            = 6'd0;
        ex2mem_bus       = '0;
        data_sram_rdata  = '0;
        data_sram_rvalid = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_zero",  64'(|mem2wb_bus), 64'd0);
        chk("rst_fwd_zero", 64'(|mem2ex_fwd), 64'd0);
        chk("rst_stallreq", 64'(stallreq_mem), 64'd0);
        chk("rst_state",    cur_state(), ST_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- ALU result passes through ----------------
        issue(mk(7'd0, 1'b0, 1'b1, 5'd5, 64'h42));
        @(negedge clk);
        chk("add_wb_we",     64'(wb_we), 64'd1);
        chk("add_wb_waddr",  64'(wb_waddr), 64'd5);
        chk("add_wb_wdata",  wb_wdata, 64'h42);
        chk("add_fwd_we",    64'(fwd_we), 64'd1);
        chk("add_fwd_waddr", 64'(fwd_waddr), 64'd5);
        chk("add_fwd_wdata", fwd_wdata, 64'h42);
        chk("add_stallreq",  64'(stallreq_mem), 64'd0);

        // ---------------- stray rvalid on a non-load ----------------
        @(posedge clk);
        #1;
        issue(mk(7'd0, 1'b0, 1'b1, 5'd3, 64'h7));
        data_sram_rvalid = 1'b1;
        data_sram_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("stray_wdata",    wb_wdata, 64'h7);
        chk("stray_stallreq", 64'(stallreq_mem), 64'd0);
        @(posedge clk);
        #1;
        data_sram_rvalid = 1'b0;
        chk("stray_state", cur_state(), ST_IDLE);

        // ---------------- same-cycle loads, every width ----------------
        run_load("lb_a3",  OP_LB,  64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("lbu_a7", OP_LBU, 64'h1007, 64'hF000_0000_0000_0000, 64'h0000_0000_0000_00F0);
        run_load("lh_a6",  OP_LH,  64'h1006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        run_load("lhu_a2", OP_LHU, 64'h1002, 64'h0000_0000_9876_0000, 64'h0000_0000_0000_9876);
        run_load("lw_a0",  OP_LW,  64'h1000, 64'h0000_0000_8765_4321, 64'hFFFF_FFFF_8765_4321);
        run_load("lwu_a4", OP_LWU, 64'h1004, 64'h9ABC_DEF0_1234_5678, 64'h0000_0000_9ABC_DEF0);
        run_load("ld_a0",  OP_LD,  64'h1000, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        // ---------------- lwu with data 3 cycles late ----------------
        issue(mk(OP_LWU, 1'b1, 1'b1, 5'd7, 64'h2004));
        stall       = 6'b011111;
        stall_cnt   = 0;
        fwd_low_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stallreq_mem) stall_cnt++;
            if (!fwd_we) fwd_low_cnt++;
            @(posedge clk);
            #1;
            if (i == 0) chk("late_state_wait", cur_state(), ST_WAIT);
        end
        chk("late_stall_cycles", 64'(stall_cnt), 64'd3);
        chk("late_fwd_we_low",   64'(fwd_low_cnt), 64'd3);
        data_sram_rvalid = 1'b1;
        data_sram_rdata  = 64'h9ABC_DEF0_1234_5678;
        stall            = 6'd0;
        @(negedge clk);
        chk("late_stallreq_drop", 64'(stallreq_mem), 64'd0);
        chk("late_wdata",         wb_wdata, 64'h0000_0000_9ABC_DEF0);
        chk("late_fwd_we",        64'(fwd_we), 64'd1);
        @(posedge clk);
        #1;
        data_sram_rvalid = 1'b0;
        chk("late_state_idle", cur_state(), ST_IDLE);

        // ---------------- ld completing under WB stall -> HOLD ----------------
        issue(mk(OP_LD, 1'b1, 1'b1, 5'd8, 64'h3000));
        stall            = 6'b011111;
        data_sram_rvalid = 1'b1;
        data_sram_rdata  = 64'h1122_3344_5566_7788;
        @(negedge clk);
        chk("hold_c0_wdata",    wb_wdata, 64'h1122_3344_5566_7788);
        chk("hold_c0_stallreq", 64'(stallreq_mem), 64'd0);
        @(posedge clk);
        #1;
        data_sram_rvalid = 1'b0;
        data_sram_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        chk("hold_c1_state",    cur_state(), ST_HOLD);
        chk("hold_c1_wdata",    wb_wdata, 64'h1122_3344_5566_7788);
        chk("hold_c1_stallreq", 64'(stallreq_mem), 64'd0);
        chk("hold_c1_fwd_we",   64'(fwd_we), 64'd1);
        @(posedge clk);
        #1;
        stall = 6'd0;
        @(negedge clk);
        chk("hold_c2_state", cur_state(), ST_HOLD);
        chk("hold_c2_wdata", wb_wdata, 64'h1122_3344_5566_7788);
        @(posedge clk);
        #1;
        chk("hold_release_state", cur_state(), ST_IDLE);

        // ---------------- misaligned lw at offset 2 ----------------
        issue(mk(OP_LW, 1'b1, 1'b1, 5'd9, 64'h4002));
        data_sram_rvalid = 1'b1;
        data_sram_rdata  = 64'h1111_2222_3333_4444;
        @(negedge clk);
        chk("mis_wdata", wb_wdata, 64'h0000_0000_2222_3333);
`ifdef MEM_MISALIGN_CHK_EN
        chk("mis_flag",   64'(wb_misalign), 64'd1);
        chk("mis_wb_we",  64'(wb_we), 64'd0);
        chk("mis_fwd_we", 64'(fwd_we), 64'd0);
`else
        chk("mis_flag",   64'(wb_misalign), 64'd0);
        chk("mis_wb_we",  64'(wb_we), 64'd1);
        chk("mis_fwd_we", 64'(fwd_we), 64'd1);
`endif
        @(posedge clk);
        #1;
        data_sram_rvalid = 1'b0;

        // ---------------- reset during WAIT, then stray rvalid ----------------
        issue(mk(OP_LW, 1'b1, 1'b1, 5'd11, 64'h5000));
        stall = 6'b011111;
        @(negedge clk);
        chk("rw_stallreq_pre", 64'(stallreq_mem), 64'd1);
        @(posedge clk);
        #1;
        chk("rw_state_wait", cur_state(), ST_WAIT);
        rst = 1'b1;
        #1;
        chk("rw_rst_stallreq", 64'(stallreq_mem), 64'd0);
        chk("rw_rst_wb",       64'(|mem2wb_bus), 64'd0);
        chk("rw_rst_fwd",      64'(|mem2ex_fwd), 64'd0);
        chk("rw_rst_state",    cur_state(), ST_IDLE);
        @(posedge clk);
        #1;
        rst              = 1'b0;
        stall            = 6'd0;
        data_sram_rvalid = 1'b1;
        data_sram_rdata  = 64'hCAFE_CAFE_CAFE_CAFE;
        @(negedge clk);
        chk("rw_stray_wb_we",    64'(wb_we), 64'd0);
        chk("rw_stray_wdata",    wb_wdata, 64'd0);
        chk("rw_stray_stallreq", 64'(stallreq_mem), 64'd0);
        @(posedge clk);
        #1;
        data_sram_rvalid = 1'b0;
        chk("rw_stray_state", cur_state(), ST_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter EX2MEM_WD, default 182, width of ex2mem_bus.
REQ-002 SHALL have parameter MEM2WB_WD, default 167, width of mem2wb_bus.
REQ-003 SHALL have parameter MEM2EX_WD, default 70, width of mem2ex_fwd.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port stall  in  6  pipeline stall vector; bit 3 = MEM input register, bit 4 = WB input register.
REQ-007 SHALL have port stallreq_mem  out  1  asserted while a load is awaiting data.
REQ-008 SHALL have port ex2mem_bus  in  EX2MEM_WD  {lsu_op[6:0], data_ram_sel[7:0], sel_load, rf_we, rf_waddr[4:0], ex_result[63:0], pc[63:0], inst[31:0]}, MSB first.
REQ-009 SHALL have port data_sram_rdata  in  64  data memory read data.
REQ-010 SHALL have port data_sram_rvalid  in  1  read data valid, one-cycle pulse per load.
REQ-011 SHALL have port mem2wb_bus  out  MEM2WB_WD  {rf_we, rf_waddr[4:0], rf_wdata[63:0], pc[63:0], inst[31:0], misalign}.
REQ-012 SHALL have port mem2ex_fwd  out  MEM2EX_WD  {rf_we, rf_waddr[4:0], rf_wdata[63:0]}.

Function
REQ-013 Input register SHALL load ex2mem_bus when !stall[3], load zero when stall[3]&!stall[4], hold otherwise.
REQ-014 lsu_op SHALL be one-hot: [6] lb, [5] lbu, [4] lh, [3] lhu, [2] lw, [1] lwu, [0] ld; all-zero = not a load.
REQ-015 Load address low bits SHALL be ex_result[2:0]; load data = data_sram_rdata shifted right by 8*ex_result[2:0].
REQ-016 lb/lh/lw SHALL sign-extend bit 7/15/31; lbu/lhu/lwu SHALL zero-extend; ld SHALL pass all 64 bits.
REQ-017 rf_wdata SHALL be extended load data when sel_load=1, else ex_result.
REQ-018 FSM states SHALL be IDLE, WAIT, HOLD; reset state IDLE.
REQ-019 IDLE: load present and rvalid=0 -> stallreq_mem=1, next WAIT; rvalid=1 and stall[4]=0 -> complete, stay IDLE; rvalid=1 and stall[4]=1 -> capture rdata into buffer, next HOLD.
REQ-020 WAIT: stallreq_mem=1 until rvalid; on rvalid, stallreq_mem=0 same cycle, data used combinationally, next IDLE (or HOLD with capture if stall[4]=1).
REQ-021 HOLD: rf_wdata SHALL use buffered data; stallreq_mem=0; return to IDLE when stall[4]=0.
REQ-022 rvalid in IDLE with no load present SHALL be ignored.
REQ-023 mem2ex_fwd rf_we SHALL be 0 while a load lacks valid data (IDLE-without-rvalid or WAIT); otherwise equal mem2wb_bus rf_we.
REQ-024 Non-load instructions SHALL pass through with zero added latency and never assert stallreq_mem.
REQ-025 Block SHALL NOT react to branch flush; the instruction in MEM is older than the branch.

Reset
REQ-026 Reset SHALL clear input register, read buffer and FSM (IDLE) asynchronously; all outputs zero during reset, including stallreq_mem.
REQ-027 Reset mid-WAIT SHALL abandon the load; a later stray rvalid SHALL be ignored per REQ-022.

Configuration
REQ-028 With MEM_MISALIGN_CHK_EN defined, misalign SHALL be 1 for lh/lhu with addr[0]!=0, lw/lwu with addr[1:0]!=0, ld with addr[2:0]!=0, and rf_we (both buses) SHALL be forced 0.
REQ-029 Without MEM_MISALIGN_CHK_EN, misalign SHALL be constant 0, and misaligned loads SHALL use the shifted data per REQ-015 with rf_we unmodified.

Verification
REQ-030 lb at addr ...3, rvalid same cycle, rdata=64'h0000_0000_8000_0000 >> ... byte3=0x80 -> rf_wdata=64'hFFFF_FFFF_FFFF_FF80, stallreq_mem never 1.
REQ-031 lwu at addr ...4, rvalid 3 cycles late, rdata=64'h9ABC_DEF0_1234_5678 -> stallreq_mem high 3 cycles, rf_wdata=64'h0000_0000_9ABC_DEF0, fwd rf_we=0 until data.
REQ-032 ld with rvalid while stall[4]=1 for 2 cycles -> FSM HOLD, rf_wdata stays buffered value, IDLE after stall[4] drops.
REQ-033 add result 64'h42 to x5 -> mem2wb and mem2ex_fwd show rf_we=1, waddr=5, wdata=64'h42 in the same cycle it is registered.
REQ-034 rst asserted during WAIT, then rvalid pulse -> outputs zero, FSM IDLE, no write.
REQ-035 MEM_MISALIGN_CHK_EN: lw at addr ...2 -> misalign=1, rf_we=0; without macro -> misalign=0, rf_we=1.
